// File: rtl/di_i2_if_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : di_ifstage_interface
// Description : Dual-issue IF-stage link between the primary IF stage (pi)
//               and the issue-2 allocator (i2).
// Revision    : 1.0 - initial release
// ============================================================================
interface di_ifstage_interface;
  logic        primary_if_valid;
  logic [31:0] pi_fetch_addr;
  logic [31:0] pi_instr_decomp;
  logic        pi_hwlp_di_prevent_cond;
  logic        i2_instr_allocated;

  modport pi (
    output primary_if_valid,
    output pi_fetch_addr,
    output pi_instr_decomp,
    output pi_hwlp_di_prevent_cond,
    input  i2_instr_allocated
  );

  modport i2 (
    input  primary_if_valid,
    input  pi_fetch_addr,
    input  pi_instr_decomp,
    input  pi_hwlp_di_prevent_cond,
    output i2_instr_allocated
  );
endinterface
`default_nettype wire

// File: rtl/di_i2_if_allocator.sv
`default_nettype none
// ============================================================================
// Module      : di_i2_if_allocator
// Description : Screens primary-issue instructions for issue-2 eligibility,
//               buffers them and hands them to the issue-2 ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
module di_i2_if_allocator #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  di_ifstage_interface.i2      ifs,
  input  logic                 i2_en_i,
  input  logic                 flush_i,
  output logic                 i2_id_valid_o,
  output logic [31:0]          i2_id_instr_o,
  output logic [31:0]          i2_id_addr_o,
  input  logic                 i2_id_ready_i,
  output logic                 i2_busy_o,
  output logic [CNT_W-1:0]     alloc_cnt_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  localparam logic [CNT_FW-1:0] c_depth     = CNT_FW'(FIFO_DEPTH);
  localparam logic [6:0]        c_op_imm    = 7'b0010011;
  localparam logic [6:0]        c_op        = 7'b0110011;
  localparam logic [6:0]        c_f7_base   = 7'b0000000;
  localparam logic [6:0]        c_f7_alt    = 7'b0100000;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_active = 2'd1;
  localparam logic [1:0] c_st_drain  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              w_active;

  logic [63:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_FW-1:0] r_count;
  logic [CNT_FW-1:0] w_count_next;
  logic [CNT_W-1:0]  r_alloc_cnt;

  logic [6:0]        w_opcode;
  logic [6:0]        w_funct7;
  logic              w_elig;
  logic              w_alloc;
  logic              w_pop;

  // Integer ALU ops only; OP with M-extension funct7 is rejected.
  assign w_opcode = ifs.pi_instr_decomp[6:0];
  assign w_funct7 = ifs.pi_instr_decomp[31:25];
  assign w_elig   = (w_opcode == c_op_imm) ||
                    ((w_opcode == c_op) && ((w_funct7 == c_f7_base) || (w_funct7 == c_f7_alt)));

  // Full blocks allocation even when the head pops this cycle.
  assign w_alloc = ifs.primary_if_valid & w_elig & ~ifs.pi_hwlp_di_prevent_cond &
                   ~flush_i & w_active & (r_count < c_depth);
  assign ifs.i2_instr_allocated = w_alloc;

  assign i2_id_valid_o = (r_count != '0);
  assign w_pop         = i2_id_valid_o & i2_id_ready_i & ~flush_i;
  assign {i2_id_addr_o, i2_id_instr_o} = r_mem[r_rd_ptr];
  assign alloc_cnt_o   = r_alloc_cnt;

  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else if (w_alloc && !w_pop) begin
      w_count_next = r_count + CNT_FW'(1);
    end else if (!w_alloc && w_pop) begin
      w_count_next = r_count - CNT_FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_alloc) begin
          r_mem[r_wr_ptr] <= {ifs.pi_fetch_addr, ifs.pi_instr_decomp};
          r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_cnt <= '0;
    end else if (w_alloc) begin
      r_alloc_cnt <= r_alloc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DRAIN leaves as soon as the FIFO will be empty after this edge (last pop or flush).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:   if (i2_en_i) w_state_next = c_st_active;
      c_st_active: if (!i2_en_i) w_state_next = (r_count != '0) ? c_st_drain : c_st_idle;
      c_st_drain:  if (w_count_next == '0) w_state_next = c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_active  = (r_state == c_st_active);
    i2_busy_o = (r_state != c_st_idle);
  end

endmodule
`default_nettype wire

// File: tb/tb_di_i2_if_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_di_i2_if_allocator
// Description : Self-checking bench for di_i2_if_allocator with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_di_i2_if_allocator;

  localparam int DEPTH = 2;
  localparam int CW    = 32;

  logic        clk;
  logic        rst_n;
  logic        pv, prev, en, flush, ready;
  logic [31:0] addr, instr;
  logic        valid, busy;
  logic [31:0] head_instr, head_addr;
  logic [CW-1:0] cnt;
  logic        alloc;

  int n_cmp = 0;
  int n_err = 0;

  di_ifstage_interface ifs_bus ();
  assign ifs_bus.primary_if_valid        = pv;
  assign ifs_bus.pi_fetch_addr           = addr;
  assign ifs_bus.pi_instr_decomp         = instr;
  assign ifs_bus.pi_hwlp_di_prevent_cond = prev;
  assign alloc                           = ifs_bus.i2_instr_allocated;

  di_i2_if_allocator #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifs           (ifs_bus),
    .i2_en_i       (en),
    .flush_i       (flush),
    .i2_id_valid_o (valid),
    .i2_id_instr_o (head_instr),
    .i2_id_addr_o  (head_addr),
    .i2_id_ready_i (ready),
    .i2_busy_o     (busy),
    .alloc_cnt_o   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of {addr, instr}, a mode (0 idle, 1 active, 2 drain), a counter.
  logic [63:0] m_q[$];
  int          m_st;
  logic [31:0] m_cnt;

  function automatic bit ref_elig(input logic [31:0] ins);
    case (ins[6:0])
      7'h13:   return 1'b1;
      7'h33:   return (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_alloc();
    return pv && ref_elig(instr) && !prev && !flush && (m_st == 1) && (m_q.size() < DEPTH);
  endfunction

  task automatic tick();
    bit a;
    int sz;
    a  = ref_alloc();
    sz = m_q.size();
    @(posedge clk);
    if (flush) begin
      m_q.delete();
    end else begin
      if (ready && sz > 0) void'(m_q.pop_front());
      if (a) m_q.push_back({addr, instr});
    end
    if (a) m_cnt = m_cnt + 1;
    case (m_st)
      0: if (en) m_st = 1;
      1: if (!en) m_st = (sz != 0) ? 2 : 0;
      2: if (m_q.size() == 0) m_st = 0;
      default: m_st = 0;
    endcase
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] i, input bit p);
    pv = v; addr = a; instr = i; prev = p;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[6:0] = 7'h13;
      1, 2: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      3: r[6:0] = 7'h03;
      4: r[6:0] = 7'h63;
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 0; flush = 0; ready = 0;
    drive(0, 32'h0, 32'h0, 0);
    m_q.delete(); m_st = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL reset_alloc: got %b want 0", alloc); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (head_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", head_instr); end
    n_cmp++; if (head_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", head_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_eligible_stream();
    en = 1; ready = 1;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL en_busy: got %b want 1", busy); end
    drive(1, 32'h100, 32'h00500093, 0); #1;
    n_cmp++; if (alloc !== 1'b1) begin n_err++; $display("FAIL addi_alloc: got %b want 1", alloc); end
    tick();
    n_cmp++; if ({valid, head_addr, head_instr} !== {1'b1, 32'h100, 32'h00500093})
      begin n_err++; $display("FAIL head_addi: got %b/%h/%h want 1/100/00500093", valid, head_addr, head_instr); end
    drive(1, 32'h104, 32'h002081B3, 0); #1;
    n_cmp++; if (alloc !== 1'b1) begin n_err++; $display("FAIL add_alloc: got %b want 1", alloc); end
    tick();
    n_cmp++; if ({valid, head_addr, head_instr} !== {1'b1, 32'h104, 32'h002081B3})
      begin n_err++; $display("FAIL head_add: got %b/%h/%h want 1/104/002081b3", valid, head_addr, head_instr); end
    drive(0, 32'h0, 32'h0, 0);
    tick();
    n_cmp++; if (cnt !== 32'd2) begin n_err++; $display("FAIL stream_cnt: got %0d want 2", cnt); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL stream_empty: got %b want 0", valid); end
  endtask

  task automatic test_ineligible();
    logic [31:0] ins [3];
    logic        pr  [3];
    ins[0] = 32'h0000A103; pr[0] = 0;
    ins[1] = 32'h022081B3; pr[1] = 0;
    ins[2] = 32'h00500093; pr[2] = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h300 + 32'(4 * k), ins[k], pr[k]); #1;
      n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL inelig_alloc%0d: got %b want 0", k, alloc); end
      tick();
    end
    drive(0, 32'h0, 32'h0, 0);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL inelig_valid: got %b want 0", valid); end
    n_cmp++; if (cnt !== 32'd2) begin n_err++; $display("FAIL inelig_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_full_wrap();
    logic exp [3];
    exp[0] = 1; exp[1] = 1; exp[2] = 0;
    ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h200 + 32'(4 * k), 32'h00100013 + 32'(k << 20), 0); #1;
      n_cmp++; if (alloc !== exp[k]) begin n_err++; $display("FAIL full_alloc%0d: got %b want %b", k, alloc, exp[k]); end
      tick();
    end
    ready = 1;
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h20C + 32'(4 * k), 32'h00208033 + 32'(k << 7), 0); #1;
      n_cmp++; if (alloc !== ref_alloc()) begin n_err++; $display("FAIL wrap_alloc%0d: got %b want %b", k, alloc, ref_alloc()); end
      n_cmp++; if (m_q.size() == 0 || {head_addr, head_instr} !== m_q[0])
        begin n_err++; $display("FAIL wrap_head%0d: got %h_%h want %h", k, head_addr, head_instr, (m_q.size() != 0) ? m_q[0] : 64'h0); end
      tick();
    end
    drive(0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 4 && m_q.size() != 0; k++) begin
      n_cmp++; if ({head_addr, head_instr} !== m_q[0])
        begin n_err++; $display("FAIL wrap_tail%0d: got %h_%h want %h", k, head_addr, head_instr, m_q[0]); end
      tick();
    end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", valid); end
  endtask

  task automatic test_flush();
    logic [31:0] saved;
    ready = 0;
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h400 + 32'(4 * k), 32'h00300113, 0);
      tick();
    end
    saved = m_cnt;
    flush = 1; ready = 1;
    drive(1, 32'h408, 32'h00300113, 0); #1;
    n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL flush_alloc: got %b want 0", alloc); end
    tick();
    flush = 0;
    drive(0, 32'h0, 32'h0, 0); #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", valid); end
    n_cmp++; if (cnt !== saved) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", cnt, saved); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_active: got %b want 1", busy); end
  endtask

  task automatic test_drain();
    ready = 0;
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h500 + 32'(4 * k), 32'h40208033, 0);
      tick();
    end
    en = 0;
    drive(1, 32'h508, 32'h40208033, 0); #1;
    n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL drain_full_alloc: got %b want 0", alloc); end
    tick();
    en = 1; ready = 1; #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b want 1", busy); end
    n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL drain_en_alloc: got %b want 0", alloc); end
    tick();
    en = 0; #1;
    n_cmp++; if ({valid, busy} !== 2'b11) begin n_err++; $display("FAIL drain_mid: got %b%b want 11", valid, busy); end
    n_cmp++; if (head_addr !== 32'h504) begin n_err++; $display("FAIL drain_head: got %h want 504", head_addr); end
    n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL drain_alloc2: got %b want 0", alloc); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", valid); end
    n_cmp++; if (busy !== (m_st != 0)) begin n_err++; $display("FAIL drain_idle: got %b want %b", busy, (m_st != 0)); end
    en = 1;
    tick();
    #1;
    n_cmp++; if (alloc !== 1'b1) begin n_err++; $display("FAIL reen_alloc: got %b want 1", alloc); end
    tick();
    drive(0, 32'h0, 32'h0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_instr(), $urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) en = ~en;
      #1;
      n_cmp++; if (alloc !== ref_alloc()) begin n_err++; $display("FAIL rnd_alloc c%0d: got %b want %b", c, alloc, ref_alloc()); end
      n_cmp++; if (valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_cmp++; if ({head_addr, head_instr} !== m_q[0])
          begin n_err++; $display("FAIL rnd_head c%0d: got %h_%h want %h", c, head_addr, head_instr, m_q[0]); end
      end
      n_cmp++; if (busy !== (m_st != 0)) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_st != 0); end
      n_cmp++; if (cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, cnt, m_cnt); end
      tick();
    end
    flush = 0;
  endtask

  task automatic test_async_reset();
    en = 1; ready = 0; flush = 0;
    drive(1, 32'h600, 32'h00A00293, 0);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (alloc !== 1'b0) begin n_err++; $display("FAIL arst_alloc: got %b want 0", alloc); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", valid); end
    n_cmp++; if ({head_addr, head_instr} !== 64'h0) begin n_err++; $display("FAIL arst_head: got %h_%h want 0", head_addr, head_instr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_cmp++; if (cnt !== '0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", cnt); end
    m_q.delete(); m_st = 0; m_cnt = 0;
    en = 0;
    drive(0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({valid, busy} !== 2'b00) begin n_err++; $display("FAIL arst_after: got %b%b want 00", valid, busy); end
  endtask

  initial begin
    test_reset();
    test_eligible_stream();
    test_ineligible();
    test_full_wrap();
    test_flush();
    test_drain();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
